// File: rtl/mdio_rd_sequencer_if.sv
// Read-path bundle between the MDIO read sequencer and the read-logic stage.
// The master issues sel/addr plus a one-cycle pulse; the slave returns the slice.
interface mdio_rd_sequencer_if #(
  parameter int SEL_W  = 7,
  parameter int ADDR_W = 15
);
  logic              rd_en;
  logic              rd_pulse;
  logic [SEL_W-1:0]  rd_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [8:0]        rd_data;

  modport master (
    output rd_en,
    output rd_pulse,
    output rd_sel,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_pulse,
    input  rd_sel,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/mdio_rd_sequencer.sv
// MDIO capture-memory read sequencer: sweeps sel (outer) and addr (inner),
// pulses one read per entry, samples the slice and holds it until host ack.
module mdio_rd_sequencer #(
  parameter int SEL_W  = 7,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rf_96path_en,
  input  logic              rf_seq_start,
  input  logic              rf_seq_abort,
  input  logic              rf_seq_single,
  input  logic [SEL_W-1:0]  rf_start_sel,
  input  logic [ADDR_W-1:0] rf_start_addr,
  input  logic              rf_data_ack,
  mdio_rd_sequencer_if.master rd,
  output logic [8:0]        seq_data,
  output logic              seq_valid,
  output logic              seq_busy,
  output logic              seq_done
);

  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_NEXT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [SEL_W-1:0]  last_sel;
  logic              addr_ones;
  logic              is_last;

  // A start sel already past the final slice ends the sweep after one read.
  assign last_sel  = rf_96path_en ? SEL_W'(95) : SEL_W'(47);
  assign addr_ones = &addr_q;
  assign is_last   = rf_seq_single
                   || (sel_q > last_sel)
                   || ((sel_q == last_sel) && addr_ones);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (rf_seq_start) begin
          state_d = S_ISSUE;
          sel_d   = rf_start_sel;
          addr_d  = rf_start_addr;
          done_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      // WAIT spans RD_LAT cycles so the sample lands RD_LAT after the pulse.
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
          data_d  = rd.rd_data;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (rf_data_ack) begin
          state_d = S_NEXT;
          valid_d = 1'b0;
        end
      end
      S_NEXT: begin
        if (is_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ISSUE;
          addr_d  = addr_q + 1'b1;
          if (addr_ones) begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the state logic chose, including a start.
    if (rf_seq_abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      done_d  = done_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      data_d  = data_q;
    end
  end

  assign rd.rd_pulse = (state_q == S_ISSUE);
  assign rd.rd_en    = (state_q == S_ISSUE)
                     || (state_q == S_WAIT)
                     || (state_q == S_HOLD)
                     || (state_q == S_NEXT);
  assign rd.rd_sel   = sel_q;
  assign rd.rd_addr  = addr_q;

  assign seq_data  = data_q;
  assign seq_valid = valid_q;
  assign seq_busy  = (state_q != S_IDLE);
  assign seq_done  = done_q;

endmodule

// File: tb/tb_mdio_rd_sequencer.sv
// Randomized bench for mdio_rd_sequencer with a list-based sweep model
// and a fixed-latency read-logic stand-in.
module tb_mdio_rd_sequencer;

  localparam int SEL_W  = 7;
  localparam int ADDR_W = 15;
  localparam int RD_LAT = 3;

  logic              clk;
  logic              rstn;
  logic              rf_96path_en;
  logic              rf_seq_start;
  logic              rf_seq_abort;
  logic              rf_seq_single;
  logic [SEL_W-1:0]  rf_start_sel;
  logic [ADDR_W-1:0] rf_start_addr;
  logic              rf_data_ack;
  logic [8:0]        seq_data;
  logic              seq_valid;
  logic              seq_busy;
  logic              seq_done;

  int n_checks;
  int n_fail;

  mdio_rd_sequencer_if #(.SEL_W(SEL_W), .ADDR_W(ADDR_W)) rif ();

  mdio_rd_sequencer #(
    .SEL_W (SEL_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rf_96path_en (rf_96path_en),
    .rf_seq_start (rf_seq_start),
    .rf_seq_abort (rf_seq_abort),
    .rf_seq_single(rf_seq_single),
    .rf_start_sel (rf_start_sel),
    .rf_start_addr(rf_start_addr),
    .rf_data_ack  (rf_data_ack),
    .rd           (rif),
    .seq_data     (seq_data),
    .seq_valid    (seq_valid),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] data_fn(input logic [21:0] e);
    return 9'((e[21:15] * 9'd37) ^ e[8:0] ^ {e[14:9], 3'b101});
  endfunction

  // Read-logic stand-in: data valid only in the cycle RD_LAT after the pulse.
  logic             fixed_en;
  logic [8:0]       fixed_val;
  logic [RD_LAT-1:0] pv;
  logic [8:0]       pd [RD_LAT];
  logic [8:0]       junk;
  logic [8:0]       src;

  assign src = fixed_en ? fixed_val : data_fn({rif.rd_sel, rif.rd_addr});
  assign rif.rd_data = pv[RD_LAT-1] ? pd[RD_LAT-1] : junk;

  always @(posedge clk) begin
    pv    <= {pv[RD_LAT-2:0], rif.rd_pulse};
    pd[0] <= src;
    for (int i = 1; i < RD_LAT; i++) pd[i] <= pd[i-1];
    junk  <= 9'($urandom);
  end

  logic [21:0] got_q[$];
  logic [8:0]  dat_q[$];
  logic [21:0] exp_q[$];
  logic        sv_prev;

  always @(negedge clk) begin
    if (rif.rd_pulse) got_q.push_back({rif.rd_sel, rif.rd_addr});
    if (seq_valid && !sv_prev) dat_q.push_back(seq_data);
    sv_prev <= seq_valid;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input logic [6:0] s, input logic [14:0] a, input bit p96, input bit single, input int maxn, output bit nat);
    int lin;
    int last;
    int cs;
    int ca;
    exp_q.delete();
    last = p96 ? 95 : 47;
    lin  = int'(s) * 32768 + int'(a);
    nat  = 1'b0;
    while (exp_q.size() < maxn) begin
      cs = lin / 32768;
      ca = lin % 32768;
      exp_q.push_back({7'(cs), 15'(ca)});
      if (single || cs > last || (cs == last && ca == 32767)) begin
        nat = 1'b1;
        break;
      end
      lin++;
    end
  endtask

  task automatic run_sweep(input logic [6:0] s, input logic [14:0] a, input bit p96, input bit single, input int maxn, input int ack_dly, input bit busy_start, output bit tmo);
    int hc;
    bit inj;
    got_q.delete();
    dat_q.delete();
    rf_start_sel  = s;
    rf_start_addr = a;
    rf_96path_en  = p96;
    rf_seq_single = single;
    rf_seq_start  = 1'b1;
    cyc();
    hc  = 0;
    inj = 1'b0;
    tmo = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rf_seq_start = 1'b0;
      rf_seq_abort = 1'b0;
      rf_data_ack  = 1'b0;
      if (!seq_busy) begin
        tmo = 1'b0;
        break;
      end
      if (busy_start && !inj && rif.rd_pulse) begin
        rf_seq_start  = 1'b1;
        rf_start_sel  = s + 7'd20;
        rf_start_addr = a ^ 15'h0055;
        inj = 1'b1;
      end
      if (got_q.size() >= maxn && !rif.rd_pulse) begin
        rf_seq_abort = 1'b1;
      end else if (seq_valid) begin
        if (hc >= ack_dly) begin
          rf_data_ack = 1'b1;
          hc = 0;
        end else begin
          hc++;
        end
      end
      cyc();
    end
    rf_seq_start = 1'b0;
    rf_seq_abort = 1'b0;
    rf_data_ack  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if ({seq_busy, seq_valid, seq_done, seq_data} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_seq got=%h want=0", {seq_busy, seq_valid, seq_done, seq_data});
    end
    n_checks++;
    if ({rif.rd_en, rif.rd_pulse, rif.rd_sel, rif.rd_addr} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_rd got=%h want=0", {rif.rd_en, rif.rd_pulse, rif.rd_sel, rif.rd_addr});
    end
    rstn = 1'b1;
    repeat (2) cyc();
    n_checks++;
    if (seq_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b want=0", seq_busy);
    end
  endtask

  task automatic test_single();
    bit tmo;
    bit nat;
    fixed_en  = 1'b1;
    fixed_val = 9'h1A5;
    build_exp(7'd0, 15'd0, 1'b0, 1'b1, 1000, nat);
    run_sweep(7'd0, 15'd0, 1'b0, 1'b1, 1000, 2, 1'b0, tmo);
    fixed_en = 1'b0;
    n_checks++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL single_timeout got=%b want=0", tmo);
    end
    n_checks++;
    if (got_q.size() !== 1) begin
      n_fail++;
      $display("FAIL single_pulses got=%0d want=1", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL single_entry got=%h want=%h", got_q[0], exp_q[0]);
      end
    end
    n_checks++;
    if (dat_q.size() !== 1 || dat_q[0] !== 9'h1A5) begin
      n_fail++;
      $display("FAIL single_data got=%h n=%0d want=1a5", (dat_q.size() > 0) ? dat_q[0] : 9'h0, dat_q.size());
    end
    n_checks++;
    if (seq_done !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done got=%b want=1", seq_done);
    end
  endtask

  task automatic sweep_case(input string nm, input logic [6:0] s, input logic [14:0] a, input bit p96, input bit single, input int maxn, input int ack_dly, input bit busy_start);
    bit tmo;
    bit nat;
    int ndat;
    build_exp(s, a, p96, single, maxn, nat);
    run_sweep(s, a, p96, single, nat ? 1000 : maxn, ack_dly, busy_start, tmo);
    n_checks++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout got=%b want=0", nm, tmo);
    end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count got=%0d want=%0d", nm, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_entry%0d got=%h want=%h", nm, i, got_q[i], exp_q[i]);
      end
    end
    ndat = nat ? exp_q.size() : exp_q.size() - 1;
    n_checks++;
    if (dat_q.size() !== ndat) begin
      n_fail++;
      $display("FAIL %s_ndata got=%0d want=%0d", nm, dat_q.size(), ndat);
    end
    for (int i = 0; i < dat_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (dat_q[i] !== data_fn(exp_q[i])) begin
        n_fail++;
        $display("FAIL %s_data%0d got=%h want=%h", nm, i, dat_q[i], data_fn(exp_q[i]));
      end
    end
    n_checks++;
    if (seq_done !== nat) begin
      n_fail++;
      $display("FAIL %s_done got=%b want=%b", nm, seq_done, nat);
    end
  endtask

  task automatic test_wrap();
    sweep_case("wrap", 7'd3, 15'h7FFE, 1'b0, 1'b0, 3, 0, 1'b0);
  endtask

  task automatic test_last();
    sweep_case("last47", 7'd47, 15'h7FFF, 1'b0, 1'b0, 4, 1, 1'b0);
    sweep_case("last95", 7'd47, 15'h7FFF, 1'b1, 1'b0, 2, 0, 1'b0);
    sweep_case("beyond", 7'd60, 15'h0005, 1'b0, 1'b0, 4, 0, 1'b0);
  endtask

  task automatic test_busy_start();
    sweep_case("busy_start", 7'd20, 15'h0010, 1'b0, 1'b0, 2, 1, 1'b1);
  endtask

  task automatic test_hold();
    int bad;
    bit seen;
    rf_start_sel  = 7'd10;
    rf_start_addr = 15'h0100;
    rf_96path_en  = 1'b0;
    rf_seq_single = 1'b0;
    rf_seq_start  = 1'b1;
    cyc();
    rf_seq_start = 1'b0;
    n_checks++;
    if (rif.rd_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_pulse got=%b want=1", rif.rd_pulse);
    end
    repeat (RD_LAT) cyc();
    n_checks++;
    if (seq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_early_valid got=%b want=0", seq_valid);
    end
    rf_data_ack = 1'b1;
    cyc();
    rf_data_ack = 1'b0;
    cyc();
    n_checks++;
    if (seq_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_early_ack got=%b want=1", seq_valid);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rif.rd_sel !== 7'd10 || rif.rd_addr !== 15'h0100) bad++;
      if (seq_data !== data_fn({7'd10, 15'h0100})) bad++;
      if (rif.rd_pulse !== 1'b0 || seq_valid !== 1'b1) bad++;
      cyc();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_stable got=%0d bad cycles want=0", bad);
    end
    rf_data_ack = 1'b1;
    cyc();
    rf_data_ack = 1'b0;
    n_checks++;
    if (rif.rd_pulse !== 1'b0 || seq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_next got=%b%b want=00", rif.rd_pulse, seq_valid);
    end
    cyc();
    n_checks++;
    if (rif.rd_pulse !== 1'b1 || rif.rd_addr !== 15'h0101) begin
      n_fail++;
      $display("FAIL hold_reissue got=%b/%h want=1/0101", rif.rd_pulse, rif.rd_addr);
    end
    rf_seq_abort = 1'b1;
    cyc();
    rf_seq_abort = 1'b0;
    seen = seq_busy;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_abort busy=%b want=0", seen);
    end
  endtask

  task automatic test_abort();
    bit tmo;
    int k;
    rf_start_sel  = 7'd5;
    rf_start_addr = 15'h0064;
    rf_seq_single = 1'b0;
    rf_seq_start  = 1'b1;
    cyc();
    rf_seq_start = 1'b0;
    cyc();
    rf_seq_abort  = 1'b1;
    rf_seq_start  = 1'b1;
    cyc();
    rf_seq_abort = 1'b0;
    rf_seq_start = 1'b0;
    n_checks++;
    if ({seq_busy, rif.rd_en, seq_valid, seq_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_wait got=%b want=0000", {seq_busy, rif.rd_en, seq_valid, seq_done});
    end
    rf_seq_start = 1'b1;
    cyc();
    rf_seq_start = 1'b0;
    k = 0;
    while (!seq_valid && k < 50) begin
      cyc();
      k++;
    end
    n_checks++;
    if (seq_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reach_hold got=%b want=1", seq_valid);
    end
    rf_seq_abort = 1'b1;
    rf_data_ack  = 1'b1;
    cyc();
    rf_seq_abort = 1'b0;
    rf_data_ack  = 1'b0;
    n_checks++;
    if ({seq_busy, rif.rd_en, seq_valid, seq_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_hold got=%b want=0000", {seq_busy, rif.rd_en, seq_valid, seq_done});
    end
    run_sweep(7'd1, 15'h0002, 1'b0, 1'b1, 1000, 0, 1'b0, tmo);
    rf_seq_abort = 1'b1;
    rf_seq_start = 1'b1;
    cyc();
    rf_seq_abort = 1'b0;
    rf_seq_start = 1'b0;
    cyc();
    n_checks++;
    if ({tmo, seq_busy, seq_done} !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_idle_start got=%b want=001", {tmo, seq_busy, seq_done});
    end
  endtask

  task automatic test_reset_mid();
    rf_start_sel  = 7'd30;
    rf_start_addr = 15'h00C8;
    rf_seq_single = 1'b0;
    rf_seq_start  = 1'b1;
    cyc();
    rf_seq_start = 1'b0;
    repeat (2) cyc();
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({seq_busy, seq_valid, seq_done, seq_data, rif.rd_en, rif.rd_pulse, rif.rd_sel, rif.rd_addr} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_mid got=%h want=0", {seq_busy, seq_valid, seq_done, seq_data, rif.rd_en, rif.rd_pulse, rif.rd_sel, rif.rd_addr});
    end
    cyc();
    rstn = 1'b1;
    cyc();
    sweep_case("after_rst", 7'd9, 15'h1234, 1'b0, 1'b1, 4, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0]  s;
    logic [14:0] a;
    bit          p96;
    bit          single;
    for (int it = 0; it < 8; it++) begin
      s      = 7'($urandom_range(40, 100));
      a      = 15'h7FFF - 15'($urandom_range(0, 3));
      p96    = 1'($urandom);
      single = ($urandom_range(0, 3) == 0);
      sweep_case("rand", s, a, p96, single, 5, $urandom_range(0, 3), 1'b0);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rstn          = 1'b0;
    rf_96path_en  = 1'b0;
    rf_seq_start  = 1'b0;
    rf_seq_abort  = 1'b0;
    rf_seq_single = 1'b0;
    rf_start_sel  = '0;
    rf_start_addr = '0;
    rf_data_ack   = 1'b0;
    fixed_en      = 1'b0;
    fixed_val     = 9'h0;
    test_reset();
    test_single();
    test_wrap();
    test_last();
    test_hold();
    test_busy_start();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
